// File: rtl/note_player_pkg.sv
// Shared definitions for the voice playback path: field widths, FSM encoding
// and the note-to-phase-step mapping used by the frequency ROM.
package note_defs;
    localparam int NOTE_WIDTH     = 6;
    localparam int DURATION_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        PLAYING = 2'b10
    } state_t;

    // Note 1 is A1 (55 Hz); each 12 notes is one octave, i.e. a doubled step.
    // Base steps are f * 2^22 / 48 kHz for the lowest octave.
    function automatic logic [19:0] note_step(input logic [NOTE_WIDTH-1:0] n);
        logic [NOTE_WIDTH-1:0] idx;
        logic [NOTE_WIDTH-1:0] semi;
        logic [NOTE_WIDTH-1:0] oct;
        logic [19:0]           base;
        idx  = n - NOTE_WIDTH'(1);
        semi = idx % NOTE_WIDTH'(12);
        oct  = idx / NOTE_WIDTH'(12);
        case (semi)
            6'd0:    base = 20'd4806;
            6'd1:    base = 20'd5092;
            6'd2:    base = 20'd5394;
            6'd3:    base = 20'd5715;
            6'd4:    base = 20'd6055;
            6'd5:    base = 20'd6415;
            6'd6:    base = 20'd6797;
            6'd7:    base = 20'd7201;
            6'd8:    base = 20'd7629;
            6'd9:    base = 20'd8083;
            6'd10:   base = 20'd8563;
            default: base = 20'd9073;
        endcase
        return (n == '0) ? 20'd0 : (base << oct);
    endfunction
endpackage

// File: rtl/note_player_frequency_rom.sv
// 64-entry note-to-step table with a registered read port; entry 0 (rest) is 0.
module frequency_rom
    import note_defs::*;
#(
    parameter int STEP_WIDTH = 20
) (
    input  logic                  clk,
    input  logic [NOTE_WIDTH-1:0] addr,
    output logic [STEP_WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        data <= STEP_WIDTH'(note_step(addr));
    end

endmodule

// File: rtl/note_player.sv
// One playback voice: accepts a note/duration, counts beats down, and advances
// a phase accumulator by the note's step on each codec sample request.
//
// state   | meaning
// IDLE    | voice free; note_done follows play
// LOAD    | ROM lookup of the latched note; zero-length notes end here
// PLAYING | counting beats and stepping phase while play is high
module note_player
    import note_defs::*;
#(
    parameter int PHASE_WIDTH = 22,
    parameter int STEP_WIDTH  = 20    // must not exceed PHASE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      new_note,
    input  logic [NOTE_WIDTH-1:0]     note,
    input  logic [DURATION_WIDTH-1:0] duration,
    input  logic                      generate_next_sample,
    output logic                      note_done,
    output logic                      busy,
    output logic [NOTE_WIDTH-1:0]     active_note,
    output logic [PHASE_WIDTH-1:0]    phase,
    output logic                      sample_valid
);

    state_t                    state;
    logic [DURATION_WIDTH-1:0] beat_cnt;
    logic [STEP_WIDTH-1:0]     step_reg;

    // The ROM output register is the step register; it settles during LOAD.
    frequency_rom #(.STEP_WIDTH(STEP_WIDTH)) u_rom (
        .clk  (clk),
        .addr (active_note),
        .data (step_reg)
    );

    // Independent of new_note so the reader can gate its strobe on it without a loop.
    assign note_done = (state == IDLE) && play;
    assign busy      = (state == LOAD) || (state == PLAYING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            phase        <= '0;
            active_note  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (play && new_note) begin
                        active_note <= note;
                        beat_cnt    <= duration;
                        phase       <= '0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    state <= (beat_cnt == '0) ? IDLE : PLAYING;
                end
                PLAYING: begin
                    if (play) begin
                        if (generate_next_sample) begin
                            phase        <= phase + PHASE_WIDTH'(step_reg);
                            sample_valid <= 1'b1;
                        end
                        if (beat) begin
                            if (beat_cnt == DURATION_WIDTH'(1))
                                state <= IDLE;
                            else
                                beat_cnt <= beat_cnt - DURATION_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Randomized and directed stimulus for one voice, checked every cycle against
// a note-lifetime reference model kept in the bench.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic       beat = 1'b0;
    logic       new_note = 1'b0;
    logic [5:0] note = '0;
    logic [5:0] duration = '0;
    logic       generate_next_sample = 1'b0;
    logic       note_done;
    logic       busy;
    logic [5:0] active_note;
    logic [21:0] phase;
    logic       sample_valid;

    note_player #(.PHASE_WIDTH(22), .STEP_WIDTH(20)) dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .beat                 (beat),
        .new_note             (new_note),
        .note                 (note),
        .duration             (duration),
        .generate_next_sample (generate_next_sample),
        .note_done            (note_done),
        .busy                 (busy),
        .active_note          (active_note),
        .phase                (phase),
        .sample_valid         (sample_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sv_seen  = 0;

    // Reference model: a note is either loading, sounding with beats left, or the voice is free.
    bit          m_loading = 1'b0;
    int          m_beats   = 0;
    logic [21:0] m_phase   = '0;
    logic [5:0]  m_note    = '0;
    bit          m_sv      = 1'b0;

    int base_step [12] = '{4806, 5092, 5394, 5715, 6055, 6415,
                           6797, 7201, 7629, 8083, 8563, 9073};

    function automatic int ref_step(input int n);
        if (n == 0) return 0;
        return base_step[(n - 1) % 12] * (2 ** ((n - 1) / 12));
    endfunction

    function automatic bit m_free();
        return !m_loading && (m_beats == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_beats   = 0;
        m_phase   = '0;
        m_note    = '0;
        m_sv      = 1'b0;
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model to the next edge.
    task automatic cyc(input bit p, input bit b, input bit nn, input int n, input int d, input bit g);
        play = p; beat = b; new_note = nn;
        note = 6'(n); duration = 6'(d); generate_next_sample = g;
        @(negedge clk);
        check("note_done",    32'(note_done),    32'(m_free() && p));
        check("busy",         32'(busy),         32'(!m_free()));
        check("active_note",  32'(active_note),  32'(m_note));
        check("phase",        32'(phase),        32'(m_phase));
        check("sample_valid", 32'(sample_valid), 32'(m_sv));
        if (sample_valid) sv_seen++;
        m_sv = 1'b0;
        if (reset) begin
            model_reset();
        end else if (m_free()) begin
            if (p && nn) begin
                m_note    = 6'(n);
                m_beats   = d;
                m_phase   = '0;
                m_loading = 1'b1;
            end
        end else if (m_loading) begin
            m_loading = 1'b0;
        end else if (p) begin
            if (g) begin
                m_phase = 22'((32'(m_phase) + ref_step(int'(m_note))) % (1 << 22));
                m_sv    = 1'b1;
            end
            if (b) m_beats--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input bit p);
        for (int i = 0; i < cycles; i++) cyc(p, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int sv_start;
        #1;
        // Load attempt while held in reset must be ignored.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 10, 3, 1'b1);
        reset = 1'b0;
        idle(2, 1'b1);

        // Note 10, duration 3, beats every 8 cycles.
        cyc(1'b1, 1'b0, 1'b1, 10, 3, 1'b0);
        for (int i = 1; i <= 32; i++) cyc(1'b1, (i % 8) == 0, 1'b0, 0, 0, 1'b0);

        // Note 10, duration 2, five sample requests.
        sv_start = sv_seen;
        cyc(1'b1, 1'b0, 1'b1, 10, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        end
        check("phase_5x_rom10", 32'(phase), 32'(5 * ref_step(10)));
        check("sv_count_5", 32'(sv_seen - sv_start), 32'd5);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);   // last beat with a final sample
        idle(2, 1'b1);

        // Duration 0: no samples, voice free two cycles after acceptance.
        sv_start = sv_seen;
        cyc(1'b1, 1'b0, 1'b1, 7, 0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        check("dur0_no_sv", 32'(sv_seen - sv_start), 32'd0);

        // Pause mid-note while beats and requests keep arriving.
        cyc(1'b1, 1'b0, 1'b1, 20, 4, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 3 == 0), 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'(i % 3 == 0), 1'b0, 0, 0, 1'b1);
        idle(2, 1'b1);

        // Largest step, many requests to wrap; new_note during PLAYING is ignored.
        cyc(1'b1, 1'b0, 1'b1, 63, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'(i % 5 == 0), 12, 9, 1'b1);
        check("active_note_held", 32'(active_note), 32'd63);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        idle(2, 1'b1);

        // Asynchronous reset mid-note with nonzero phase.
        cyc(1'b1, 1'b0, 1'b1, 30, 5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        check("pre_reset_phase", 32'(phase), 32'(3 * ref_step(30)));
        #2 reset = 1'b1;
        #1;
        check("rst_phase",       32'(phase),        32'd0);
        check("rst_active_note", 32'(active_note),  32'd0);
        check("rst_busy",        32'(busy),         32'd0);
        check("rst_sample_valid",32'(sample_valid), 32'd0);
        check("rst_note_done",   32'(note_done),    32'(play));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 63)),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
                $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
